// File: rtl/prefix_byte_queue.sv
// Byte-granular instruction queue that strips REP / operand-size / segment prefixes
// one byte per cycle and presents the prefix summary plus three post-prefix bytes to decode.
module prefix_byte_queue #(
  parameter int DEPTH  = 16,
  parameter int FILL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                fetch_valid,
  input  logic [8*FILL_W-1:0] fetch_data,
  input  logic [3:0]          fetch_nbytes,
  output logic                fetch_ready,
  output logic                dec_valid,
  input  logic                dec_ready,
  input  logic [3:0]          instr_len,
  output logic                isREP,
  output logic                isSIZE,
  output logic                isSEG,
  output logic [3:0]          prefSize,
  output logic [5:0]          segSEL,
  output logic [7:0]          B1,
  output logic [7:0]          B2,
  output logic [7:0]          B3
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {SCAN, PRESENT, DRAIN} state_t;

  state_t           state_reg;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [2:0]       pcnt_reg;
  logic [3:0]       deficit_reg;
  logic             rep_reg;
  logic             size_reg;
  logic             seg_reg;
  logic [5:0]       segsel_reg;

  logic [PTR_W-1:0] scan_addr;
  logic [7:0]       scan_byte;
  logic             scan_is_rep;
  logic             scan_is_size;
  logic             scan_is_pfx;
  logic [5:0]       scan_seg;

  logic             in_drain;
  logic             fill_acc;
  logic             hs;
  logic             pop_ok;
  logic [3:0]       discard_n;
  logic [3:0]       store_n;
  logic [3:0]       deficit_left;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] len_w;
  logic [8*FILL_W-1:0] shifted_data;

  logic [7:0]       lane_byte [FILL_W];
  logic [PTR_W-1:0] lane_addr [FILL_W];
  logic [FILL_W-1:0] lane_en;

  // The scanner always looks at the byte just past the prefixes consumed so far.
  assign scan_addr = head_reg + PTR_W'(pcnt_reg);
  assign scan_byte = mem[scan_addr];

  always_comb begin
    scan_is_rep  = 1'b0;
    scan_is_size = 1'b0;
    scan_seg     = 6'b000000;
    case (scan_byte)
      8'hF3:   scan_is_rep  = 1'b1;
      8'h66:   scan_is_size = 1'b1;
      8'h26:   scan_seg     = 6'b000001;
      8'h2E:   scan_seg     = 6'b000010;
      8'h36:   scan_seg     = 6'b000100;
      8'h3E:   scan_seg     = 6'b001000;
      8'h64:   scan_seg     = 6'b010000;
      8'h65:   scan_seg     = 6'b100000;
      default: ;
    endcase
  end
  assign scan_is_pfx = scan_is_rep | scan_is_size | (|scan_seg);

  assign in_drain    = (state_reg == DRAIN);
  assign fetch_ready = in_drain || ((CNT_W'(DEPTH) - count_reg) >= CNT_W'(FILL_W));
  assign fill_acc    = fetch_valid && fetch_ready && !flush;

  // While draining, the oldest bytes of a beat belong to the over-long instruction.
  assign discard_n    = (fill_acc && in_drain) ?
                        ((deficit_reg < fetch_nbytes) ? deficit_reg : fetch_nbytes) : 4'd0;
  assign store_n      = fill_acc ? (fetch_nbytes - discard_n) : 4'd0;
  assign deficit_left = deficit_reg - discard_n;
  assign avail        = count_reg + CNT_W'(store_n);
  assign len_w        = CNT_W'(instr_len);
  assign hs           = (state_reg == PRESENT) && dec_ready;
  assign pop_ok       = (len_w <= avail);
  assign shifted_data = fetch_data >> {discard_n, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < FILL_W; gi++) begin : g_lane
      assign lane_byte[gi] = shifted_data[8*gi +: 8];
      assign lane_addr[gi] = tail_reg + PTR_W'(gi);
      assign lane_en[gi]   = fill_acc && (4'(gi) < store_n);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= SCAN;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      pcnt_reg    <= '0;
      deficit_reg <= '0;
      rep_reg     <= 1'b0;
      size_reg    <= 1'b0;
      seg_reg     <= 1'b0;
      segsel_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (flush) begin
      state_reg   <= SCAN;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      pcnt_reg    <= '0;
      deficit_reg <= '0;
      rep_reg     <= 1'b0;
      size_reg    <= 1'b0;
      seg_reg     <= 1'b0;
      segsel_reg  <= '0;
    end else begin
      for (int i = 0; i < FILL_W; i++) begin
        if (lane_en[i]) mem[lane_addr[i]] <= lane_byte[i];
      end
      tail_reg  <= tail_reg + PTR_W'(store_n);
      count_reg <= avail;
      case (state_reg)
        SCAN: begin
          if (count_reg > CNT_W'(pcnt_reg) && scan_is_pfx && pcnt_reg < 3'd4) begin
            pcnt_reg <= pcnt_reg + 3'd1;
            rep_reg  <= rep_reg | scan_is_rep;
            size_reg <= size_reg | scan_is_size;
            if (|scan_seg) begin
              seg_reg    <= 1'b1;
              segsel_reg <= scan_seg;
            end
          end else if (count_reg >= CNT_W'(pcnt_reg) + CNT_W'(3)) begin
            state_reg <= PRESENT;
          end
        end
        PRESENT: begin
          if (hs) begin
            pcnt_reg   <= '0;
            rep_reg    <= 1'b0;
            size_reg   <= 1'b0;
            seg_reg    <= 1'b0;
            segsel_reg <= '0;
            if (pop_ok) begin
              head_reg  <= head_reg + PTR_W'(instr_len);
              count_reg <= avail - len_w;
              state_reg <= SCAN;
            end else begin
              // Instruction runs past the buffered bytes: drop everything and skip the rest.
              head_reg    <= tail_reg + PTR_W'(store_n);
              count_reg   <= '0;
              deficit_reg <= 4'(len_w - avail);
              state_reg   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          deficit_reg <= deficit_left;
          if (deficit_left == 4'd0) state_reg <= SCAN;
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  assign dec_valid = (state_reg == PRESENT);
  assign isREP     = rep_reg;
  assign isSIZE    = size_reg;
  assign isSEG     = seg_reg;
  assign segSEL    = segsel_reg;
  assign prefSize  = {1'b0, pcnt_reg};
  assign B1        = scan_byte;
  assign B2        = mem[scan_addr + PTR_W'(1)];
  assign B3        = mem[scan_addr + PTR_W'(2)];

endmodule

// File: tb/tb_prefix_byte_queue.sv
// Randomized bench for prefix_byte_queue against a byte-queue reference model.
module tb_prefix_byte_queue;
  localparam int DEPTH     = 16;
  localparam int FILL_W    = 8;
  localparam int M_SCAN    = 0;
  localparam int M_PRESENT = 1;
  localparam int M_DRAIN   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic [63:0] fetch_data;
  logic [3:0]  fetch_nbytes;
  logic        fetch_ready;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  instr_len;
  logic        isREP;
  logic        isSIZE;
  logic        isSEG;
  logic [3:0]  prefSize;
  logic [5:0]  segSEL;
  logic [7:0]  B1;
  logic [7:0]  B2;
  logic [7:0]  B3;

  prefix_byte_queue #(.DEPTH(DEPTH), .FILL_W(FILL_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_nbytes(fetch_nbytes),
    .fetch_ready(fetch_ready), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .instr_len(instr_len), .isREP(isREP), .isSIZE(isSIZE), .isSEG(isSEG),
    .prefSize(prefSize), .segSEL(segSEL), .B1(B1), .B2(B2), .B3(B3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the buffered bytes as a plain queue plus the scan summary.
  logic [7:0] q [$];
  int         m_mode;
  int         m_pcnt;
  int         m_def;
  bit         m_rep;
  bit         m_size;
  bit         m_seg;
  logic [5:0] m_segsel;

  logic [7:0] pfx_tab [8] = '{8'hF3, 8'h66, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] seg_code(input logic [7:0] b);
    logic [5:0] r;
    r = 6'b000000;
    if (b == 8'h26) r = 6'b000001;
    if (b == 8'h2E) r = 6'b000010;
    if (b == 8'h36) r = 6'b000100;
    if (b == 8'h3E) r = 6'b001000;
    if (b == 8'h64) r = 6'b010000;
    if (b == 8'h65) r = 6'b100000;
    return r;
  endfunction

  function automatic bit is_prefix(input logic [7:0] b);
    return (b == 8'hF3) || (b == 8'h66) || (seg_code(b) != 6'b000000);
  endfunction

  task automatic clear_prefix();
    m_pcnt = 0; m_rep = 0; m_size = 0; m_seg = 0; m_segsel = 6'b000000;
  endtask

  task automatic model_clear();
    q.delete();
    m_mode = M_SCAN;
    m_def  = 0;
    clear_prefix();
  endtask

  task automatic record(input logic [7:0] b);
    if (b == 8'hF3) m_rep = 1;
    if (b == 8'h66) m_size = 1;
    if (seg_code(b) != 6'b000000) begin
      m_seg    = 1;
      m_segsel = seg_code(b);
    end
    m_pcnt++;
  endtask

  task automatic compare_all(input bit b_zero);
    chk("dec_valid", 32'(dec_valid), 32'(m_mode == M_PRESENT));
    chk("fetch_ready", 32'(fetch_ready), 32'((m_mode == M_DRAIN) || ((DEPTH - q.size()) >= FILL_W)));
    chk("isREP", 32'(isREP), 32'(m_rep));
    chk("isSIZE", 32'(isSIZE), 32'(m_size));
    chk("isSEG", 32'(isSEG), 32'(m_seg));
    chk("prefSize", 32'(prefSize), m_pcnt);
    chk("segSEL", 32'(segSEL), 32'(m_segsel));
    if (b_zero) begin
      chk("B1_rst", 32'(B1), 0);
      chk("B2_rst", 32'(B2), 0);
      chk("B3_rst", 32'(B3), 0);
    end else if (m_mode == M_PRESENT) begin
      chk("B1", 32'(B1), 32'(q[m_pcnt]));
      chk("B2", 32'(B2), 32'(q[m_pcnt+1]));
      chk("B3", 32'(B3), 32'(q[m_pcnt+2]));
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance the
  // model across the coming rising edge, then compare at the next falling edge.
  task automatic step(input bit fv, input logic [63:0] data, input int nb,
                      input bit dr, input int il, input bit fl);
    bit rdy;
    bit acc;
    logic [7:0] b;
    fetch_valid  = fv;
    fetch_data   = data;
    fetch_nbytes = 4'(nb);
    dec_ready    = dr;
    instr_len    = 4'(il);
    flush        = fl;
    rdy = (m_mode == M_DRAIN) || ((DEPTH - q.size()) >= FILL_W);
    acc = fv && rdy;
    if (fl) begin
      model_clear();
    end else begin
      case (m_mode)
        M_SCAN: begin
          if (q.size() > m_pcnt) begin
            if (is_prefix(q[m_pcnt]) && m_pcnt < 4) record(q[m_pcnt]);
            else if (q.size() >= m_pcnt + 3) m_mode = M_PRESENT;
          end
          if (acc) for (int i = 0; i < nb; i++) q.push_back(data[8*i +: 8]);
        end
        M_PRESENT: begin
          if (acc) for (int i = 0; i < nb; i++) q.push_back(data[8*i +: 8]);
          if (dr) begin
            $display("xact t=%0t len=%0d pref=%0d b1=%02h buffered=%0d", $time, il, m_pcnt,
                     q[m_pcnt], q.size());
            if (il <= q.size()) begin
              repeat (il) void'(q.pop_front());
              m_mode = M_SCAN;
            end else begin
              m_def = il - q.size();
              q.delete();
              m_mode = M_DRAIN;
            end
            clear_prefix();
          end
        end
        default: begin
          if (acc) begin
            for (int i = 0; i < nb; i++) begin
              b = data[8*i +: 8];
              if (m_def > 0) m_def--;
              else q.push_back(b);
            end
            if (m_def == 0) m_mode = M_SCAN;
          end
        end
      endcase
    end
    @(negedge clk);
    compare_all(0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 64'h0, 1, 0, 1, 0);
  endtask

  task automatic async_reset();
    fetch_valid = 0; dec_ready = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1 model_clear();
    compare_all(1);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all(1);
  endtask

  function automatic logic [63:0] rand_beat();
    logic [63:0] d;
    for (int i = 0; i < FILL_W; i++) begin
      if ($urandom_range(0, 9) < 4) d[8*i +: 8] = pfx_tab[$urandom_range(0, 7)];
      else d[8*i +: 8] = 8'($urandom);
    end
    return d;
  endfunction

  initial begin
    bit fv;
    bit dr;
    bit fl;
    int nb;
    int il;
    rst_n = 1'b0; flush = 0; fetch_valid = 0; fetch_data = '0;
    fetch_nbytes = 4'd1; dec_ready = 0; instr_len = 4'd1;
    model_clear();
    repeat (2) @(negedge clk);
    compare_all(1);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all(1);

    // Plain opcode, no prefixes: valid one cycle after the write
    step(1, 64'h9090_9090_9090_D889, 8, 0, 1, 0);
    chk("t1_not_yet", 32'(dec_valid), 0);
    idle(1);
    chk("t1_B1", 32'(B1), 32'h89);
    chk("t1_B2", 32'(B2), 32'hD8);
    chk("t1_B3", 32'(B3), 32'h90);
    step(0, 64'h0, 1, 1, 2, 0);
    idle(1);
    chk("t1_next_B1", 32'(B1), 32'h90);
    step(0, 64'h0, 1, 1, 6, 0);

    // Four mixed prefixes
    step(1, 64'h0000_00A5_642E_F366, 8, 0, 1, 0);
    idle(5);
    chk("t2_valid", 32'(dec_valid), 1);
    chk("t2_flags", 32'({isREP, isSIZE, isSEG}), 32'h7);
    chk("t2_segSEL", 32'(segSEL), 32'h10);
    chk("t2_prefSize", 32'(prefSize), 4);
    chk("t2_B1", 32'(B1), 32'hA5);
    step(0, 64'h0, 1, 1, 8, 0);

    // Fifth prefix-valued byte is the opcode
    step(1, 64'h0000_0F26_2626_2626, 8, 0, 1, 0);
    idle(5);
    chk("t3_prefSize", 32'(prefSize), 4);
    chk("t3_B1", 32'(B1), 32'h26);
    chk("t3_B2", 32'(B2), 32'h0F);
    chk("t3_segSEL", 32'(segSEL), 32'h01);
    step(0, 64'h0, 1, 1, 8, 0);

    // Short instruction: DRAIN skips the missing tail bytes
    step(1, 64'h0000_0000_0090_9090, 3, 0, 1, 0);
    idle(1);
    step(0, 64'h0, 1, 1, 7, 0);
    chk("t4_drain_ready", 32'(fetch_ready), 1);
    step(1, 64'h0000_6655_4433_2211, 6, 0, 1, 0);
    step(1, 64'h0000_0000_0000_0077, 1, 0, 1, 0);
    idle(1);
    chk("t4_B1", 32'(B1), 32'h55);
    chk("t4_B2", 32'(B2), 32'h66);
    chk("t4_B3", 32'(B3), 32'h77);
    step(0, 64'h0, 1, 1, 3, 0);

    // Back-pressure: outputs hold, fetch_ready drops, then fill + pop together
    step(1, 64'h9090_9090_9090_90C7, 8, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      step(1, 64'h9090_9090_9090_9090, 8, 0, 1, 0);
      chk("t5_hold_B1", 32'(B1), 32'hC7);
    end
    chk("t5_full_ready", 32'(fetch_ready), 0);
    step(0, 64'h0, 1, 1, 8, 0);
    idle(1);
    step(1, 64'h0000_0000_9090_9090, 4, 1, 3, 0);
    chk("t5_ready_cnt9", 32'(fetch_ready), 0);
    idle(1);
    step(0, 64'h0, 1, 1, 9, 0);
    chk("t5_ready_empty", 32'(fetch_ready), 1);

    // Flush during PRESENT drops the concurrent beat
    step(1, 64'h9090_9090_9090_9090, 8, 0, 1, 0);
    idle(1);
    step(1, 64'h1111_1111_1111_1111, 8, 0, 1, 1);
    chk("t6_valid", 32'(dec_valid), 0);
    chk("t6_ready", 32'(fetch_ready), 1);
    idle(3);

    // Randomized traffic with a mid-run asynchronous reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) async_reset();
      fv = ($urandom_range(0, 9) < 7);
      nb = $urandom_range(1, FILL_W);
      dr = ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0 || q.size() == 0) il = $urandom_range(1, 15);
      else il = $urandom_range(1, (q.size() < 15) ? q.size() : 15);
      step(fv, rand_beat(), nb, dr, il, fl);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/prefix_byte_queue.md
# prefix_byte_queue

Byte-granular instruction queue and prefix scanner that sits directly upstream of the control-store overwrite stage. It buffers fetched instruction bytes and strips legacy prefixes (REP, operand-size, segment override) one byte per cycle. It then presents the prefix summary (isREP, isSIZE, isSEG, prefSize, segSEL) and the first three post-prefix bytes (B1, B2, B3) to decode over a valid/ready handshake. On each accepted instruction it pops the instruction length reported by decode.

## Interface
- DEPTH, 16, byte buffer depth; power of two, at least 16
- FILL_W, 8, max bytes accepted per fetch beat
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous redirect; empties the queue
- fetch_valid  in  1  fetch beat valid
- fetch_data  in  8*FILL_W  bytes; byte 0 in [7:0] is the oldest
- fetch_nbytes  in  4  valid byte count, 1..FILL_W
- fetch_ready  out  1  high when free entries >= FILL_W
- dec_valid  out  1  prefix summary and B1..B3 valid
- dec_ready  in  1  decode accepts
- instr_len  in  4  total length including prefixes, 1..15; sampled on handshake
- isREP, isSIZE, isSEG  out  1 each  prefix flags
- prefSize  out  4  number of prefix bytes consumed, 0..4
- segSEL  out  6  one-hot segment override: bit0 ES, 1 CS, 2 SS, 3 DS, 4 FS, 5 GS
- B1, B2, B3  out  8 each  bytes at head+prefSize, +1, +2

## Operation
- Storage: circular buffer with head and tail pointers modulo DEPTH, plus a count register (log2(DEPTH)+1 bits).
- Fill occurs on fetch_valid && fetch_ready and is ignored otherwise. It writes fetch_nbytes bytes at the tail and advances the tail.
- Prefix codes:
  - F3 sets isREP.
  - 66 sets isSIZE.
  - 26/2E/36/3E/64/65 set isSEG and load segSEL one-hot. A later segment prefix replaces an earlier one.
  - All other bytes, including F2 and F0, are treated as opcode.
- States:
  - SCAN:
    - Examines the byte at head+pcnt when count > pcnt.
    - If that byte is a prefix and pcnt < 4: record it, pcnt++, stay in SCAN.
    - Otherwise, when count >= pcnt+3: go to PRESENT.
    - Otherwise wait in SCAN.
    - A 5th prefix-valued byte is taken as the opcode.
  - PRESENT:
    - dec_valid = 1.
    - All outputs are held stable until dec_ready.
    - On handshake:
      - If instr_len <= count post-fill: pop instr_len, clear the prefix registers and pcnt, go to SCAN.
      - Otherwise: set deficit = instr_len - count, empty the queue, go to DRAIN.
  - DRAIN:
    - Discard incoming fetch bytes, up to deficit, from the low end of the beat.
    - Write the remainder into the queue and decrement deficit.
    - When deficit reaches 0, go to SCAN in the same cycle as the last discard.
    - fetch_ready = 1 throughout DRAIN.
- Simultaneous fill and pop in the same cycle: count_next = count + nbytes - instr_len. Fill lands at the tail and is unaffected by the pop.
- flush:
  - Highest priority.
  - Sets head = tail = count = 0, clears pcnt, prefix registers and deficit, forces SCAN.
  - A fetch beat in the same cycle is dropped.
- prefSize equals pcnt; B1..B3 are read combinationally from registered pointers.

## Timing
- Reset values:
  - State SCAN; count, pointers, pcnt, deficit = 0.
  - dec_valid = 0; isREP/isSIZE/isSEG = 0; prefSize = 0; segSEL = 0; B1..B3 = 0.
  - fetch_ready = 1.
- Latency for an instruction with p prefixes, all bytes present: dec_valid rises p+1 cycles after the bytes are written.
- fetch_ready is combinational from registered count: high when DEPTH - count >= FILL_W.
- After a handshake, dec_valid is low for at least one cycle (the SCAN cycle).
- Deasserting rst_n mid-operation clears all state immediately. The first valid output comes only from fills after release.

## Test plan
- Reset, then fill 8 bytes 89 D8 90 90 90 90 90 90 -> dec_valid at cycle 1 after the write. prefSize = 0, B1 = 89, B2 = D8, B3 = 90. Handshake with instr_len = 2 -> count 6, next presentation B1 = 90.
- Fill 66 F3 2E 64 A5 00 00 00 -> four SCAN cycles, then dec_valid. isSIZE = isREP = isSEG = 1, segSEL = 6'b010000 (FS), prefSize = 4, B1 = A5.
- Fill 26 26 26 26 26 0F 00 00 -> prefSize = 4, B1 = 26 (5th prefix taken as opcode), segSEL = 6'b000001.
- Present with count = 3, handshake instr_len = 7 -> DRAIN with deficit 4. Next beat of 6 bytes: 4 discarded, 2 stored, state SCAN.
- Hold dec_ready = 0 for 5 cycles while fills continue until fetch_ready drops at count > 8 -> outputs stable. Fill plus pop in the same cycle yields the correct count.
- Assert flush during PRESENT together with fetch_valid -> next cycle dec_valid = 0, count = 0, the beat is lost, fetch_ready = 1.
